// File: rtl/lsu_core.sv
// Load/store unit: accepts one request from the execute unit, issues a single bus
// transfer with lane-positioned data and strobes, and returns an extended load result.
module lsu_core #(
    parameter int unsigned REG_W  = 32,
    parameter int unsigned STRB_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reqValid,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [REG_W-1:0]  addr,
    input  logic [REG_W-1:0]  wdata,
    output logic              respValid,
    output logic [REG_W-1:0]  rdata,
    output logic              err,
    output logic              mem_reqValid,
    input  logic              mem_reqReady,
    output logic              mem_wen,
    output logic [REG_W-1:0]  mem_addr,
    output logic [REG_W-1:0]  mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_respValid,
    input  logic [REG_W-1:0]  mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic               is_store_q;
    logic               is_unsigned_q;
    logic               err_q;
    logic [1:0]         size_q;
    logic [REG_W-1:0]   addr_q;
    logic [REG_W-1:0]   wdata_q;
    logic [REG_W-1:0]   rdata_q;
    logic [REG_W-1:0]   load_ext;
    logic [REG_W-1:0]   lane_wdata;
    logic [STRB_W-1:0]  strb;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic               misaligned;
    logic               accept;

    assign accept = (state_q == StIdle) && reqValid;

    // Size 3 is treated like a misalignment: it never reaches the bus.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (reqValid) state_d = misaligned ? StDone : StReq;
            StReq:   if (mem_reqReady) state_d = StWait;
            StWait:  if (mem_respValid) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            2'd0:    load_ext = {{(REG_W-8){~is_unsigned_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = {{(REG_W-16){~is_unsigned_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        strb       = '1;
        lane_wdata = wdata_q;
        case (size_q)
            2'd0: begin
                strb       = STRB_W'(1) << addr_q[1:0];
                lane_wdata = {STRB_W{wdata_q[7:0]}};
            end
            2'd1: begin
                strb       = addr_q[1] ? STRB_W'(4'b1100) : STRB_W'(4'b0011);
                lane_wdata = {(STRB_W/2){wdata_q[15:0]}};
            end
            default: begin
                strb       = '1;
                lane_wdata = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            is_store_q    <= 1'b0;
            is_unsigned_q <= 1'b0;
            err_q         <= 1'b0;
            size_q        <= 2'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q    <= is_store;
                is_unsigned_q <= is_unsigned;
                size_q        <= size;
                addr_q        <= addr;
                wdata_q       <= wdata;
                err_q         <= misaligned;
                rdata_q       <= '0;
            end else if (state_q == StWait && mem_respValid) begin
                rdata_q <= is_store_q ? '0 : load_ext;
            end
        end
    end

    assign respValid    = (state_q == StDone);
    assign err          = respValid & err_q;
    assign rdata        = rdata_q;
    assign mem_reqValid = (state_q == StReq);
    assign mem_wen      = mem_reqValid & is_store_q;
    assign mem_wstrb    = mem_wen ? strb : '0;
    assign mem_addr     = {addr_q[REG_W-1:2], 2'b00};
    assign mem_wdata    = lane_wdata;

endmodule

// File: tb/tb_lsu_core.sv
// Self-checking bench for lsu_core: directed cases, randomized transactions with
// random bus stalls, and reset aborts, checked against an arithmetic reference model.
module tb_lsu_core;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid, is_store, is_unsigned;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        respValid, err;
    logic [31:0] rdata;
    logic        mem_reqValid, mem_reqReady, mem_wen, mem_respValid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_pass  = 0;
    int n_total = 0;

    lsu_core #(.REG_W(32), .STRB_W(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .reqValid      (reqValid),
        .is_store      (is_store),
        .size          (size),
        .is_unsigned   (is_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .respValid     (respValid),
        .rdata         (rdata),
        .err           (err),
        .mem_reqValid  (mem_reqValid),
        .mem_reqReady  (mem_reqReady),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: plain arithmetic on the access rules.
    function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << (a % 4));
        if (sz == 2'd1) return (a % 4 >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> ((a % 4) * 8)) % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = (w >> ((a % 4 >= 2) ? 16 : 0)) % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // One transaction starting in IDLE; ends sampled in IDLE after completion.
    task automatic run_txn(input string name, input logic st, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rw, input int rdly, input int sdly);
        logic        mis, exp_req, exp_rv, exp_err;
        logic [31:0] e_rdata, e_wdata;
        logic [3:0]  e_strb;
        int          final_k, lat;
        mis     = model_misaligned(sz, a);
        e_rdata = (mis || st) ? 32'h0 : model_load(sz, uns, a, rw);
        e_strb  = st ? model_strb(sz, a) : 4'h0;
        e_wdata = model_wdata(sz, wd);
        final_k = mis ? 0 : rdly + sdly + 2;
        lat     = -1;
        reqValid = 1'b1; is_store = st; size = sz; is_unsigned = uns; addr = a; wdata = wd;
        mem_reqReady = 1'($urandom); mem_respValid = 1'($urandom); mem_rdata = $urandom;
        @(posedge clock); #1;
        for (int k = 0; k <= final_k; k++) begin
            exp_req = !mis && k <= rdly;
            exp_rv  = (k == final_k);
            exp_err = exp_rv && mis;
            n_total++;
            if (respValid !== exp_rv)
                $display("FAIL %s respValid k=%0d got %b want %b", name, k, respValid, exp_rv);
            else n_pass++;
            n_total++;
            if (mem_reqValid !== exp_req)
                $display("FAIL %s mem_reqValid k=%0d got %b want %b", name, k, mem_reqValid, exp_req);
            else n_pass++;
            n_total++;
            if (err !== exp_err)
                $display("FAIL %s err k=%0d got %b want %b", name, k, err, exp_err);
            else n_pass++;
            if (exp_req) begin
                n_total++;
                if (mem_addr !== (a - a % 4) || mem_wen !== st || mem_wstrb !== e_strb)
                    $display("FAIL %s bus fields k=%0d got addr=%h wen=%b strb=%b want addr=%h wen=%b strb=%b",
                             name, k, mem_addr, mem_wen, mem_wstrb, a - a % 4, st, e_strb);
                else n_pass++;
                if (st) begin
                    n_total++;
                    if (mem_wdata !== e_wdata)
                        $display("FAIL %s mem_wdata k=%0d got %h want %h", name, k, mem_wdata, e_wdata);
                    else n_pass++;
                end
            end else begin
                n_total++;
                if (mem_wen !== 1'b0 || mem_wstrb !== 4'h0)
                    $display("FAIL %s idle bus k=%0d got wen=%b strb=%b want 0/0", name, k, mem_wen, mem_wstrb);
                else n_pass++;
            end
            if (exp_rv) begin
                n_total++;
                if (rdata !== e_rdata)
                    $display("FAIL %s rdata got %h want %h", name, rdata, e_rdata);
                else n_pass++;
            end
            if (respValid === 1'b1 && lat < 0) lat = k + 2;
            // Scramble everything the DUT must ignore while busy.
            reqValid = 1'($urandom); is_store = 1'($urandom); size = 2'($urandom);
            is_unsigned = 1'($urandom); addr = $urandom; wdata = $urandom;
            mem_reqReady  = (k <= rdly) ? (k == rdly) : 1'($urandom);
            if (!mis && k == rdly + 1 + sdly) mem_respValid = 1'b1;
            else if (!mis && k > rdly && k < rdly + 1 + sdly) mem_respValid = 1'b0;
            else mem_respValid = 1'($urandom);
            mem_rdata = (!mis && k == rdly + 1 + sdly) ? rw : $urandom;
            @(posedge clock); #1;
        end
        reqValid = 1'b0; mem_reqReady = 1'b0; mem_respValid = 1'b0;
        n_total++;
        if (respValid !== 1'b0 || err !== 1'b0 || mem_reqValid !== 1'b0)
            $display("FAIL %s after-done got rv=%b err=%b mreq=%b want 0/0/0", name, respValid, err, mem_reqValid);
        else n_pass++;
        n_total++;
        if (rdata !== e_rdata)
            $display("FAIL %s rdata hold got %h want %h", name, rdata, e_rdata);
        else n_pass++;
        n_total++;
        if (lat !== (mis ? 2 : 4 + rdly + sdly))
            $display("FAIL %s latency got %0d want %0d", name, lat, mis ? 2 : 4 + rdly + sdly);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0; reqValid = 1'b1; is_store = 1'b1; size = 2'd2; is_unsigned = 1'b0;
        addr = 32'h100; wdata = 32'hFFFF_FFFF; mem_reqReady = 1'b1; mem_respValid = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if (respValid !== 1'b0 || err !== 1'b0 || mem_reqValid !== 1'b0 || mem_wen !== 1'b0 ||
            mem_wstrb !== 4'h0 || rdata !== 32'h0)
            $display("FAIL reset outputs got rv=%b err=%b mreq=%b wen=%b strb=%b rdata=%h want all 0",
                     respValid, err, mem_reqValid, mem_wen, mem_wstrb, rdata);
        else n_pass++;
        reqValid = 1'b0; mem_reqReady = 1'b0; mem_respValid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        n_total++;
        if (respValid !== 1'b0 || mem_reqValid !== 1'b0)
            $display("FAIL reset release got rv=%b mreq=%b want 0/0", respValid, mem_reqValid);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_txn("ld_byte_signed", 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h8011_2233, 0, 0);
        run_txn("st_half_hi", 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF, 32'h0, 0, 0);
        run_txn("ld_word_misaligned", 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h1234_5678, 0, 0);
        run_txn("ld_word_stall", 1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 32'hCAFE_F00D, 3, 1);
        run_txn("ld_half_unsigned", 1'b0, 2'd1, 1'b1, 32'h4002, 32'h0, 32'h9ABC_1234, 0, 0);
        run_txn("st_byte_lane1", 1'b1, 2'd0, 1'b0, 32'h6001, 32'h1234_56A5, 32'h0, 1, 0);
        run_txn("illegal_size", 1'b1, 2'd3, 1'b0, 32'h7000, 32'h1111_1111, 32'h0, 0, 0);
        run_txn("st_word", 1'b1, 2'd2, 1'b0, 32'h8004, 32'hDEAD_BEEF, 32'h0, 0, 2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd2) ? 2'b00 : {a[1], 1'b0} & {1'b1, sz == 2'd0};
            run_txn("random", 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        // Abort in WAIT, then a late bus response must not complete anything.
        reqValid = 1'b1; is_store = 1'b0; size = 2'd2; is_unsigned = 1'b0; addr = 32'h9000;
        @(posedge clock); #1;
        reqValid = 1'b0; mem_reqReady = 1'b1;
        @(posedge clock); #1;
        mem_reqReady = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (respValid !== 1'b0 || mem_reqValid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0)
            $display("FAIL reset_wait outputs got rv=%b mreq=%b rdata=%h err=%b want 0", respValid,
                     mem_reqValid, rdata, err);
        else n_pass++;
        @(posedge clock); #1;
        reset = 1'b1; mem_respValid = 1'b1; mem_rdata = 32'h5555_5555;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            n_total++;
            if (respValid !== 1'b0 || mem_reqValid !== 1'b0)
                $display("FAIL reset_wait late resp k=%0d got rv=%b mreq=%b want 0/0", k, respValid,
                         mem_reqValid);
            else n_pass++;
        end
        mem_respValid = 1'b0;
        // Abort in REQ: the bus request must drop immediately and not come back.
        reqValid = 1'b1; is_store = 1'b1; size = 2'd2; addr = 32'hA000; wdata = 32'h1;
        @(posedge clock); #1;
        reqValid = 1'b0;
        n_total++;
        if (mem_reqValid !== 1'b1)
            $display("FAIL reset_req pre got mreq=%b want 1", mem_reqValid);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (mem_reqValid !== 1'b0 || mem_wen !== 1'b0 || mem_wstrb !== 4'h0)
            $display("FAIL reset_req async got mreq=%b wen=%b strb=%b want 0", mem_reqValid, mem_wen,
                     mem_wstrb);
        else n_pass++;
        @(posedge clock); #1;
        reset = 1'b1; mem_reqReady = 1'b1; mem_respValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            n_total++;
            if (respValid !== 1'b0 || mem_reqValid !== 1'b0)
                $display("FAIL reset_req after k=%0d got rv=%b mreq=%b want 0/0", k, respValid,
                         mem_reqValid);
            else n_pass++;
        end
        mem_reqReady = 1'b0; mem_respValid = 1'b0;
        run_txn("post_reset_load", 1'b0, 2'd0, 1'b1, 32'hB002, 32'h0, 32'h00F7_0000, 1, 1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_core.md
LSU_CORE -- requirements
Module: lsu_core

Interface
REQ-001 SHALL have parameter REG_W, default 32, data and address width in bits.
REQ-002 SHALL have parameter STRB_W, default 4, byte-strobe width (REG_W/8).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; state is cleared while reset=0.
REQ-005 SHALL have port reqValid  input  1  execute-unit request strobe, sampled only in IDLE.
REQ-006 SHALL have port is_store  input  1  1=store, 0=load.
REQ-007 SHALL have port size  input  2  access size: 0=byte, 1=half, 2=word; 3 is illegal.
REQ-008 SHALL have port is_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend.
REQ-009 SHALL have port addr  input  REG_W  byte address.
REQ-010 SHALL have port wdata  input  REG_W  store data, right-aligned.
REQ-011 SHALL have port respValid  output  1  one-cycle completion pulse to the execute unit.
REQ-012 SHALL have port rdata  output  REG_W  extended load result, valid from respValid until the next accept.
REQ-013 SHALL have port err  output  1  misaligned or illegal-size flag, qualified by respValid.
REQ-014 SHALL have port mem_reqValid  output  1  bus request.
REQ-015 SHALL have port mem_reqReady  input  1  bus accepts the request.
REQ-016 SHALL have port mem_wen  output  1  bus write enable.
REQ-017 SHALL have port mem_addr  output  REG_W  word-aligned address ({addr[REG_W-1:2],2'b00}).
REQ-018 SHALL have port mem_wdata  output  REG_W  lane-positioned store data.
REQ-019 SHALL have port mem_wstrb  output  STRB_W  byte-lane strobes (0 for loads).
REQ-020 SHALL have port mem_respValid  input  1  bus response strobe (reads and writes).
REQ-021 SHALL have port mem_rdata  input  REG_W  bus read word.

Function
REQ-022 SHALL implement the states IDLE, REQ, WAIT, DONE.
REQ-023 In IDLE with reqValid=1, SHALL latch is_store, size, is_unsigned, addr, and wdata, then go to REQ; reqValid in any other state SHALL be ignored.
REQ-024 A misaligned request SHALL go from IDLE to DONE with err=1, issue no bus request, and return rdata=0. Misaligned means: size=3; or half with addr[0]=1; or word with addr[1:0]!=0.
REQ-025 In REQ, mem_reqValid SHALL be 1 and the mem_* fields SHALL be held stable until the cycle with mem_reqReady=1, after which the state SHALL be WAIT.
REQ-026 In WAIT, on mem_respValid=1, SHALL register the load result into rdata and go to DONE.
REQ-027 In DONE, SHALL assert respValid=1 for exactly one cycle and then return to IDLE.
REQ-028 Minimum latency with zero-wait-state memory (reqReady and respValid both immediate) SHALL be 4 cycles: accept -> REQ -> WAIT -> DONE.
REQ-029 Store strobes SHALL be: byte 1<<addr[1:0]; half 4'b0011 for addr[1]=0, 4'b1100 for addr[1]=1; word 4'b1111.
REQ-030 Store data SHALL be wdata[7:0] replicated in all four lanes for a byte store, and wdata[15:0] replicated twice for a half store.
REQ-031 Loads SHALL select byte mem_rdata[8*addr[1:0]+:8] or half mem_rdata[16*addr[1]+:16], then sign- or zero-extend to REG_W.
REQ-032 mem_respValid outside WAIT SHALL be ignored.
REQ-033 mem_reqReady outside REQ SHALL be ignored.
REQ-034 rdata SHALL be 0 after store completion.
REQ-035 err SHALL be 0 whenever respValid=0.

Reset
REQ-036 While reset=0, SHALL force state=IDLE and respValid, err, mem_reqValid, mem_wen, and mem_wstrb to 0, and rdata to 0.
REQ-037 Reset asserted mid-transaction (REQ or WAIT) SHALL abort the transaction; a late mem_respValid after reset release SHALL be ignored and SHALL produce no respValid.

Verification
REQ-038 Load byte signed, addr=0x1003, mem_rdata=0x80112233, zero wait -> respValid 4 cycles after accept, rdata=0xFFFFFF80, err=0.
REQ-039 Store half, addr=0x2002, wdata=0x0000BEEF -> mem_addr=0x2000, mem_wstrb=4'b1100, mem_wdata=0xBEEFBEEF, mem_wen=1.
REQ-040 Load word, addr=0x3001 -> no mem_reqValid, respValid 2 cycles after accept, err=1, rdata=0.
REQ-041 mem_reqReady held low 3 cycles then high, mem_respValid 2 cycles later -> mem_* stable throughout, exactly one respValid pulse.
REQ-042 Load halfword unsigned, addr=0x4002, mem_rdata=0x9ABC1234 -> rdata=0x00009ABC.
REQ-043 reset=0 during WAIT, then mem_respValid=1 after release -> state IDLE, respValid stays 0.
